// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, credit-gated write-port arbiter for a shared sync FIFO
// Bounded bursts per requester; registered DIN/WRITE drive the FIFO pins directly.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int BURST_LEN  = 2,
  localparam int OCC_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DIN,
  output logic [NUM_REQ-1:0]            GNT,
  input  logic                          FIFO_FULL,
  input  logic                          FIFO_READ,
  output logic                          FIFO_WRITE,
  output logic [DATA_WIDTH-1:0]         FIFO_DIN,
  output logic [ID_WIDTH-1:0]           WR_ID,
  output logic [OCC_WIDTH-1:0]          OCC,
  output logic                          ERR
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0]        BURST_MAX = BW'(BURST_LEN);
  localparam logic [OCC_WIDTH-1:0] OCC_MAX   = OCC_WIDTH'(DEPTH);
  localparam logic [ID_WIDTH:0]    NUM_W     = (ID_WIDTH + 1)'(NUM_REQ);

  logic [ID_WIDTH-1:0]   owner;
  logic [BW-1:0]         burst_cnt;
  logic [ID_WIDTH-1:0]   winner;
  logic                  renew;
  logic                  found;
  logic [ID_WIDTH:0]     sum;
  logic                  can_grant;
  logic [DATA_WIDTH-1:0] sel_din;

  assign can_grant = RESET && (OCC < OCC_MAX) && !FIFO_FULL && (|REQ);

  // burst_cnt==0 means no burst is open (after reset), so the scan decides.
  always_comb begin
    winner = '0;
    renew  = 1'b1;
    found  = 1'b0;
    sum    = '0;
    if (REQ[owner] && (burst_cnt != '0) && (burst_cnt < BURST_MAX)) begin
      winner = owner;
      renew  = 1'b0;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        sum = {1'b0, owner} + (ID_WIDTH + 1)'(k);
        if (sum >= NUM_W) sum = sum - NUM_W;
        if (!found && REQ[sum[ID_WIDTH-1:0]]) begin
          found  = 1'b1;
          winner = sum[ID_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    GNT = '0;
    if (can_grant) GNT[winner] = 1'b1;
  end

  always_comb begin
    sel_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_WIDTH'(i)) sel_din = REQ_DIN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      owner      <= ID_WIDTH'(NUM_REQ - 1);
      burst_cnt  <= '0;
      FIFO_WRITE <= 1'b0;
      FIFO_DIN   <= '0;
      WR_ID      <= '0;
      OCC        <= '0;
      ERR        <= 1'b0;
    end else begin
      FIFO_WRITE <= can_grant;
      if (can_grant) begin
        owner     <= winner;
        burst_cnt <= renew ? BW'(1) : burst_cnt + BW'(1);
        FIFO_DIN  <= sel_din;
        WR_ID     <= winner;
      end
      if (can_grant && !FIFO_READ) begin
        OCC <= OCC + OCC_WIDTH'(1);
      end else if (FIFO_READ && !can_grant && (OCC != '0)) begin
        OCC <= OCC - OCC_WIDTH'(1);
      end
      // A read the credit count cannot account for is an underflow.
      if (FIFO_READ && (OCC == '0)) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         resetn;
  logic [3:0]   req;
  logic [127:0] req_din;
  logic [3:0]   gnt;
  logic         fifo_full;
  logic         fifo_read;
  logic         fifo_write;
  logic [31:0]  fifo_din;
  logic [1:0]   wr_id;
  logic [3:0]   occ;
  logic         err;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] din_tab[4];
  int          order[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  fifo_wr_arbiter #(
    .NUM_REQ(4), .ID_WIDTH(2), .DATA_WIDTH(32), .DEPTH(8), .BURST_LEN(2)
  ) dut (
    .CLK(clk), .RESET(resetn), .REQ(req), .REQ_DIN(req_din), .GNT(gnt),
    .FIFO_FULL(fifo_full), .FIFO_READ(fifo_read), .FIFO_WRITE(fifo_write),
    .FIFO_DIN(fifo_din), .WR_ID(wr_id), .OCC(occ), .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] d);
    wr_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] g, input int o);
    #1;
    chk({tag, " gnt"}, 32'(gnt), 32'(g));
    chk({tag, " occ"}, 32'(occ), 32'(o));
  endtask

  always @(negedge clk) begin
    if (fifo_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected write", 32'(fifo_write), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mon wr_id", 32'(wr_id), 32'(e.id));
        chk("mon fifo_din", fifo_din, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    din_tab[0] = 32'hA0A0_0001;
    din_tab[1] = 32'hB1B1_0002;
    din_tab[2] = 32'hC2C2_0003;
    din_tab[3] = 32'hD3D3_0004;
    resetn    = 1'b0;
    req       = 4'hF;
    fifo_read = 1'b0;
    fifo_full = 1'b0;
    req_din   = {din_tab[3], din_tab[2], din_tab[1], din_tab[0]};

    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst fifo_write", 32'(fifo_write), 32'd0);
      chk("rst occ", 32'(occ), 32'd0);
      chk("rst err", 32'(err), 32'd0);
    end

    tick();
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_cyc("sat", 4'(1 << order[i]), i);
      push(order[i], din_tab[order[i]]);
      if (i > 0) begin
        chk("sat fifo_write", 32'(fifo_write), 32'd1);
        chk("sat wr_id", 32'(wr_id), 32'(order[i-1]));
      end
      tick();
    end
    expect_cyc("sat full", 4'b0000, 8);
    tick();
    expect_cyc("sat hold", 4'b0000, 8);
    tick();

    fifo_read = 1'b1;
    expect_cyc("bubble", 4'b0000, 8);
    tick();
    fifo_read = 1'b0;
    expect_cyc("refill", 4'b0001, 7);
    push(0, din_tab[0]);
    tick();
    expect_cyc("refull", 4'b0000, 8);

    req = 4'b0000;
    fifo_read = 1'b1;
    repeat (8) tick();
    fifo_read = 1'b0;
    #1;
    chk("drain occ", 32'(occ), 32'd0);

    req = 4'b0100;
    req_din[95:64] = 32'hDEADBEEF;
    expect_cyc("sole first", 4'b0100, 0);
    push(2, 32'hDEADBEEF);
    tick();
    fifo_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_cyc("sole", 4'b0100, 1);
      push(2, 32'hDEADBEEF);
      tick();
    end
    req = 4'b0000;
    expect_cyc("sole end", 4'b0000, 1);
    tick();
    fifo_read = 1'b0;
    #1;
    chk("sole drained occ", 32'(occ), 32'd0);

    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      expect_cyc("fill", 4'b0001, i);
      push(0, din_tab[0]);
      tick();
    end
    fifo_read = 1'b1;
    expect_cyc("simul", 4'b0001, 5);
    push(0, din_tab[0]);
    tick();
    req = 4'b0000;
    fifo_read = 1'b0;
    #1;
    chk("simul occ", 32'(occ), 32'd5);

    fifo_read = 1'b1;
    repeat (2) tick();
    fifo_read = 1'b0;
    fifo_full = 1'b1;
    req = 4'hF;
    expect_cyc("full", 4'b0000, 3);
    tick();
    expect_cyc("full hold", 4'b0000, 3);
    chk("full fifo_write", 32'(fifo_write), 32'd0);
    fifo_full = 1'b0;
    req = 4'b0000;

    fifo_read = 1'b1;
    repeat (3) tick();
    #1;
    chk("pre-err occ", 32'(occ), 32'd0);
    chk("pre-err err", 32'(err), 32'd0);
    tick();
    fifo_read = 1'b0;
    #1;
    chk("underflow err", 32'(err), 32'd1);
    chk("underflow occ", 32'(occ), 32'd0);
    repeat (2) tick();
    #1;
    chk("sticky err", 32'(err), 32'd1);

    req = 4'b0100;
    expect_cyc("burst2", 4'b0100, 0);
    push(2, 32'hDEADBEEF);
    tick();
    resetn = 1'b0;
    #1;
    chk("midrst gnt", 32'(gnt), 32'd0);
    chk("midrst inflight", 32'(fifo_write), 32'd1);
    tick();
    resetn = 1'b1;
    req = 4'hF;
    expect_cyc("restart", 4'b0001, 0);
    chk("restart err", 32'(err), 32'd0);
    chk("restart fifo_write", 32'(fifo_write), 32'd0);
    push(0, din_tab[0]);
    tick();
    req = 4'b0000;
    repeat (2) tick();
    #1;
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
